// File: rtl/axi_slave_mem.sv
// Word-addressed AXI slave memory with independent write (AW/W/B) and read (AR/R) FSMs.
// Optional macro AXI_SLV_WSTRB_EN enables per-byte write strobes; otherwise full-word writes.
module axi_slave_mem #(
    parameter int unsigned DEPTH = 256
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  awid,
    input  logic [3:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic [3:0]  wid,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic [3:0]  bid,
    output logic        bvalid,
    input  logic        bready,
    input  logic [31:0] araddr,
    input  logic [3:0]  arid,
    input  logic [3:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic [3:0]  rid,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

    logic [31:0] mem [DEPTH];

    w_state_e    w_state_q, w_state_d;
    logic [29:0] aw_addr_q, aw_addr_d;
    logic [3:0]  aw_id_q, aw_id_d, aw_len_q, aw_len_d, w_cnt_q, w_cnt_d;
    logic        aw_fixed_q, aw_fixed_d, aw_bad_q, aw_bad_d;
    logic        dec_q, dec_d, lerr_q, lerr_d;
    logic        awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic [1:0]  bresp_q, bresp_d;
    logic [3:0]  bid_q, bid_d;

    logic [29:0] w_idx;
    logic        w_in_range, w_hs, w_last_beat, mem_we;
    logic [3:0]  w_be;

`ifdef AXI_SLV_WSTRB_EN
    logic unused_inputs;
    always_comb unused_inputs = ^{wid, awaddr[1:0], araddr[1:0]};
    always_comb w_be = wstrb;
`else
    logic unused_inputs;
    always_comb unused_inputs = ^{wid, wstrb, awaddr[1:0], araddr[1:0]};
    always_comb w_be = 4'hF;
`endif

    always_comb begin
        w_idx       = aw_fixed_q ? aw_addr_q : aw_addr_q + 30'(w_cnt_q);
        w_in_range  = w_idx < 30'(DEPTH);
        w_hs        = wready_q & wvalid;
        w_last_beat = (w_cnt_q == aw_len_q);
        mem_we      = w_hs & ~aw_bad_q & w_in_range & ~areset;

        w_state_d  = w_state_q;
        aw_addr_d  = aw_addr_q;
        aw_id_d    = aw_id_q;
        aw_len_d   = aw_len_q;
        aw_fixed_d = aw_fixed_q;
        aw_bad_d   = aw_bad_q;
        w_cnt_d    = w_cnt_q;
        dec_d      = dec_q;
        lerr_d     = lerr_q;
        awready_d  = awready_q;
        wready_d   = wready_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        bid_d      = bid_q;
        case (w_state_q)
            W_IDLE: begin
                awready_d = 1'b1;
                if (awvalid && awready_q) begin
                    aw_addr_d  = awaddr[31:2];
                    aw_id_d    = awid;
                    aw_len_d   = awlen;
                    aw_fixed_d = (awburst == 2'b00);
                    aw_bad_d   = (awsize != 3'b010) || awburst[1];
                    w_cnt_d    = '0;
                    dec_d      = 1'b0;
                    lerr_d     = 1'b0;
                    awready_d  = 1'b0;
                    wready_d   = 1'b1;
                    w_state_d  = W_DATA;
                end
            end
            W_DATA: begin
                if (w_hs) begin
                    w_cnt_d = 4'(w_cnt_q + 4'd1);
                    if (!w_in_range) dec_d = 1'b1;
                    if (wlast != w_last_beat) lerr_d = 1'b1;
                    if (w_last_beat) begin
                        // Response folds in the final beat's own checks, not yet registered.
                        wready_d  = 1'b0;
                        bvalid_d  = 1'b1;
                        bid_d     = aw_id_q;
                        if (aw_bad_q || lerr_q || (wlast != w_last_beat)) bresp_d = 2'b10;
                        else if (dec_q || !w_in_range)                   bresp_d = 2'b11;
                        else                                             bresp_d = 2'b00;
                        w_state_d = W_RESP;
                    end
                end
            end
            default: begin
                if (bready) begin
                    bvalid_d  = 1'b0;
                    bresp_d   = '0;
                    bid_d     = '0;
                    awready_d = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            w_state_q  <= W_IDLE;
            aw_addr_q  <= '0;
            aw_id_q    <= '0;
            aw_len_q   <= '0;
            aw_fixed_q <= 1'b0;
            aw_bad_q   <= 1'b0;
            w_cnt_q    <= '0;
            dec_q      <= 1'b0;
            lerr_q     <= 1'b0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= '0;
            bid_q      <= '0;
        end else begin
            w_state_q  <= w_state_d;
            aw_addr_q  <= aw_addr_d;
            aw_id_q    <= aw_id_d;
            aw_len_q   <= aw_len_d;
            aw_fixed_q <= aw_fixed_d;
            aw_bad_q   <= aw_bad_d;
            w_cnt_q    <= w_cnt_d;
            dec_q      <= dec_d;
            lerr_q     <= lerr_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            bid_q      <= bid_d;
        end
    end

    always_ff @(posedge aclk) begin
        if (mem_we) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (w_be[b]) mem[w_idx[AW-1:0]][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    r_state_e    r_state_q, r_state_d;
    logic [29:0] ar_addr_q, ar_addr_d;
    logic [3:0]  ar_len_q, ar_len_d, r_cnt_q, r_cnt_d;
    logic        ar_fixed_q, ar_fixed_d, ar_bad_q, ar_bad_d;
    logic        arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic [3:0]  rid_q, rid_d;

    logic        ld, ld_bad, ld_last;
    logic [29:0] ld_idx;

    always_comb begin
        r_state_d  = r_state_q;
        ar_addr_d  = ar_addr_q;
        ar_len_d   = ar_len_q;
        ar_fixed_d = ar_fixed_q;
        ar_bad_d   = ar_bad_q;
        r_cnt_d    = r_cnt_q;
        arready_d  = arready_q;
        rvalid_d   = rvalid_q;
        rlast_d    = rlast_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        rid_d      = rid_q;
        ld         = 1'b0;
        ld_bad     = 1'b0;
        ld_last    = 1'b0;
        ld_idx     = '0;
        case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (arvalid && arready_q) begin
                    ar_addr_d  = araddr[31:2];
                    ar_len_d   = arlen;
                    ar_fixed_d = (arburst == 2'b00);
                    ar_bad_d   = (arsize != 3'b010) || arburst[1];
                    r_cnt_d    = '0;
                    rid_d      = arid;
                    arready_d  = 1'b0;
                    rvalid_d   = 1'b1;
                    ld         = 1'b1;
                    ld_idx     = araddr[31:2];
                    ld_bad     = (arsize != 3'b010) || arburst[1];
                    ld_last    = (arlen == 4'd0);
                    r_state_d  = R_DATA;
                end
            end
            default: begin
                if (rvalid_q && rready) begin
                    if (rlast_q) begin
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        rdata_d   = '0;
                        rresp_d   = '0;
                        rid_d     = '0;
                        arready_d = 1'b1;
                        r_state_d = R_IDLE;
                    end else begin
                        r_cnt_d = 4'(r_cnt_q + 4'd1);
                        ld      = 1'b1;
                        ld_idx  = ar_fixed_q ? ar_addr_q : ar_addr_q + 30'(r_cnt_q) + 30'd1;
                        ld_bad  = ar_bad_q;
                        ld_last = (4'(r_cnt_q + 4'd1) == ar_len_q);
                    end
                end
            end
        endcase
        if (ld) begin
            rlast_d = ld_last;
            if (ld_bad) begin
                rresp_d = 2'b10;
                rdata_d = '0;
            end else if (ld_idx >= 30'(DEPTH)) begin
                rresp_d = 2'b11;
                rdata_d = '0;
            end else begin
                rresp_d = 2'b00;
                rdata_d = mem[ld_idx[AW-1:0]];
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state_q  <= R_IDLE;
            ar_addr_q  <= '0;
            ar_len_q   <= '0;
            ar_fixed_q <= 1'b0;
            ar_bad_q   <= 1'b0;
            r_cnt_q    <= '0;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= '0;
            rid_q      <= '0;
        end else begin
            r_state_q  <= r_state_d;
            ar_addr_q  <= ar_addr_d;
            ar_len_q   <= ar_len_d;
            ar_fixed_q <= ar_fixed_d;
            ar_bad_q   <= ar_bad_d;
            r_cnt_q    <= r_cnt_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rlast_q    <= rlast_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            rid_q      <= rid_d;
        end
    end

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;
    assign bid     = bid_q;
    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rlast   = rlast_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign rid     = rid_q;
endmodule

// File: doc/axi_slave_mem.md
# axi_slave_mem

Word-addressed AXI responder backed by an internal register-array memory; it is the slave end of the team's AXI interface bundle. It accepts write-address/write-data/write-response and read-address/read-data transactions, including FIXED and INCR bursts up to 16 beats. The block serves as the DUT-side memory model in the protocol verification environment. Read and write channels run independently.

## Interface
- DEPTH, 256: memory size in 32-bit words; power of two, ≥ 16.
- aclk  in  1  clock; all logic on the rising edge.
- areset  in  1  reset, synchronous, active-high.
- awaddr  in  32  byte address of the first write beat.
- awvalid / awready  in / out  1  write-address handshake.
- awid  in  4  write transaction ID.
- awlen  in  4  beats minus 1.
- awsize  in  3  beat size; only 3'b010 (4 bytes) is legal.
- awburst  in  2  burst type: 00 FIXED, 01 INCR, others illegal.
- wdata  in  32  write data.
- wstrb  in  4  byte lanes.
- wid  in  4  write data ID; ignored.
- wlast  in  1  last write beat marker.
- wvalid / wready  in / out  1  write-data handshake.
- bresp  out  2  00 OKAY, 10 SLVERR, 11 DECERR.
- bid  out  4  echoes the latched awid.
- bvalid / bready  out / in  1  write-response handshake.
- araddr, arid, arlen, arsize, arburst  in  32/4/4/3/2  read address; same rules as the write side.
- arvalid / arready  in / out  1  read-address handshake.
- rdata  out  32  read data.
- rresp  out  2  per-beat response.
- rid  out  4  echoes the latched arid.
- rlast  out  1  marks the final read beat.
- rvalid / rready  out / in  1  read-data handshake.

## Operation
- Address decode: word index is addr[31:2]; addr[1:0] is ignored. A beat is in range when the word index is < DEPTH. No 4 KB boundary check.
- Beat address: FIXED keeps the start address for every beat; INCR adds 4 per beat.
- Write FSM states: W_IDLE → W_DATA → W_RESP → W_IDLE.
  - W_IDLE: awready=1. On AW handshake, latch addr/id/len/burst/size, clear the beat counter and go to W_DATA.
  - W_DATA: wready=1. Each W handshake writes the beat's enabled bytes if the burst is legal and the beat is in range, then increments the counter. After handshake of beat awlen+1, go to W_RESP.
  - W_RESP: bvalid=1 until bready, then W_IDLE.
- Write bresp priority:
  - SLVERR if the size or burst is illegal, or if wlast does not match the beat position (high early or low on the final beat).
  - Otherwise DECERR if any beat was out of range.
  - Otherwise OKAY.
  - Illegal bursts suppress all memory writes; out-of-range beats suppress only themselves.
  - The burst always ends after awlen+1 beats, regardless of wlast.
- Read FSM states: R_IDLE → R_DATA → R_IDLE.
  - R_IDLE: arready=1. On AR handshake, latch fields and load beat 0 into the output registers.
  - R_DATA: rvalid=1. On each handshake, load the next beat; rlast=1 on beat arlen. After the last handshake, go to R_IDLE.
- Read rresp:
  - SLVERR on every beat if the size or burst is illegal.
  - Otherwise DECERR on out-of-range beats, OKAY on the rest.
  - rdata is 0 on any non-OKAY beat.
- Memory contents are not reset.

## Timing
- During reset all outputs are 0 and both FSMs go to idle. awready and arready go to 1 on the first cycle after areset falls.
- Reset mid-transaction aborts it: no bvalid is issued, and writes already committed stay in memory.
- AW handshake at cycle N → wready=1 at N+1.
- Last W handshake at cycle M → bvalid=1 at M+1. bvalid, bresp and bid hold stable until bready.
- AR handshake at cycle N → rvalid=1 with beat 0 at N+1. Beats stream back-to-back while rready=1. rdata, rresp, rid and rlast hold while rready=0.
- The memory is read when a beat is loaded. A write committed on the same edge is not visible (read-old-data).
- awready=0 outside W_IDLE; arready=0 outside R_IDLE. At most one outstanding transaction per direction.
- Write and read transactions may overlap in any order.

## Configuration
- AXI_SLV_WSTRB_EN defined: only bytes whose wstrb bit is 1 are written; wstrb=4'b0000 writes nothing and still returns OKAY.
- AXI_SLV_WSTRB_EN undefined: wstrb is ignored and every accepted beat writes the full 32-bit word.

## Test plan
- Single write: awaddr=0x10, wdata=0xDEADBEEF, wstrb=4'hF, awid=3 → bresp=00, bid=3. Then a single read of 0x10 with arid=5 → rdata=0xDEADBEEF, rresp=00, rid=5, rlast=1, rvalid one cycle after the AR handshake.
- INCR write, 4 beats (awlen=3) at 0x20 with data 1..4, then an INCR read, 4 beats, with rready toggling every cycle → data 1,2,3,4 in order, rlast only on beat 4, data held while rready=0.
- Address out of range (DEPTH=256): INCR write of 2 beats starting at 0x3FC → bresp=11; word 255 is written, beat 2 is dropped. A read of the same range → rresp 00 then 11, with rdata 0 on beat 2.
- Illegal burst or size: awburst=2'b10 or awsize=3'b001 → every beat accepted, no memory change, bresp=10. wlast high on beat 1 of a 2-beat burst → bresp=10.
- Strobes: write 0xFFFFFFFF, then wstrb=4'b0101 with 0x11223344 → readback 0xFF22FF44 with AXI_SLV_WSTRB_EN defined, 0x11223344 without.
- Reset asserted during W_DATA after beat 1 of 4 → all outputs 0 during reset, no bvalid afterwards, awready=1 on the first cycle after release.
